// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - sink-side VGA timing recovery, checking and lock detection
//
// Purpose: consumes active-low hSyncIn/vSyncIn from a timing generator on the
// same pixelClk, measures line and frame timing, verifies it against the
// parameters, declares lock after LOCK_FRAMES consecutive good frames, and
// regenerates x/y coordinates and visibility flags.
//
// Ports:
//   pixelClk     in   1   pixel clock, all logic on posedge
//   rst          in   1   synchronous reset, active-high
//   hSyncIn      in   1   hsync, active-low
//   vSyncIn      in   1   vsync, active-low
//   lockedOut    out  1   timing verified and tracking
//   xCor         out  10  recovered x (lags generator x by one cycle)
//   yCor         out  10  recovered y
//   hVis         out  1   lockedOut & xCor < H_VISIBLE
//   vVis         out  1   lockedOut & yCor < V_VISIBLE
//   de           out  1   hVis & vVis
//   measHPeriod  out  11  last hsync fall-to-fall period, cycles
//   measVLines   out  10  last vsync fall-to-fall period, lines
//   errCount     out  16  (ERROR_COUNT_EN only) saturating LOCKED->SEARCH count
//
// Optional feature macro: ERROR_COUNT_EN
module vga_timing_rx #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_LEN   = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_LEN   = 2,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        pixelClk,
  input  logic        rst,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  output logic        lockedOut,
  output logic [9:0]  xCor,
  output logic [9:0]  yCor,
  output logic        hVis,
  output logic        vVis,
  output logic        de,
  output logic [10:0] measHPeriod,
  output logic [9:0]  measVLines
`ifdef ERROR_COUNT_EN
  ,
  output logic [15:0] errCount
`endif
);

  localparam logic [9:0]  X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_LOAD  = 10'(H_SYNC_START);
  localparam logic [9:0]  Y_LOAD  = 10'(V_SYNC_START);
  localparam logic [9:0]  X_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]  Y_VIS   = 10'(V_VISIBLE);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] H_SLEN  = 11'(H_SYNC_LEN);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] V_SLEN  = 11'(V_SYNC_LEN);
  localparam logic [10:0] H_WD    = 11'(2 * H_TOTAL);
  localparam logic [10:0] V_WD    = 11'(2 * V_TOTAL);
  localparam logic [10:0] CNT_MAX = '1;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state_q;
  logic [3:0]  good_q;
  logic        frame_err_q, locked_q;
  logic        hs_q, vs_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] hper_q, hper_d, hwid_q, hwid_d;
  logic [10:0] vlines_q, vlines_d, vwid_q, vwid_d;
  logic        hseen_q, hseen_d, vseen_q, vseen_d;
  logic [10:0] meas_h_q, meas_h_d;
  logic [9:0]  meas_v_q, meas_v_d;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  // Edges compare the incoming sample with the registered one, so the fall is
  // seen in the same cycle the generator shows H_SYNC_START; this makes
  // xCor(t) equal the generator x of the previous cycle.
  logic hs_fall, hs_rise, vs_fall;
  assign hs_fall = hs_q & ~hSyncIn;
  assign hs_rise = ~hs_q & hSyncIn;
  assign vs_fall = vs_q & ~vSyncIn;

  // Period is only meaningful once a previous fall has been observed.
  logic h_bad, v_bad, wd_bad, drop;
  assign h_bad  = (hs_fall & hseen_q & (hper_q != H_TOT)) |
                  (hs_rise & (hwid_q != H_SLEN));
  assign v_bad  = vs_fall & ((vlines_q != V_TOT) | (vwid_q != V_SLEN));
  assign wd_bad = (hper_q > H_WD) | (vlines_q > V_WD);
  assign drop   = (state_q == LOCKED) & (h_bad | v_bad | wd_bad);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    hper_d   = hs_fall ? 11'd1 : sat_inc(hper_q);
    hwid_d   = hwid_q;
    vlines_d = vlines_q;
    vwid_d   = vwid_q;
    hseen_d  = hseen_q | hs_fall;
    vseen_d  = vseen_q | vs_fall;
    meas_h_d = (hs_fall & hseen_q) ? hper_q : meas_h_q;
    meas_v_d = (vs_fall & vseen_q) ? vlines_q[9:0] : meas_v_q;

    if (hs_fall)            x_d = X_LOAD;
    else if (x_q == X_LAST) x_d = '0;
    else                    x_d = x_q + 10'd1;

    if (vs_fall)                      y_d = Y_LOAD;
    else if (!hs_fall && x_q == X_LAST) y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;

    if (hs_fall)    hwid_d = 11'd1;
    else if (!hs_q) hwid_d = sat_inc(hwid_q);

    // A hsync fall coincident with the vsync fall belongs to the new frame.
    if (vs_fall) begin
      vlines_d = {10'd0, hs_fall};
      vwid_d   = {10'd0, hs_fall};
    end else if (hs_fall) begin
      vlines_d = sat_inc(vlines_q);
      if (!vs_q) vwid_d = sat_inc(vwid_q);
    end

    if (drop) begin
      hseen_d = 1'b0;
      vseen_d = 1'b0;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (rst) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      hper_q   <= '0;
      hwid_q   <= '0;
      vlines_q <= '0;
      vwid_q   <= '0;
      hseen_q  <= 1'b0;
      vseen_q  <= 1'b0;
      meas_h_q <= '0;
      meas_v_q <= '0;
    end else begin
      hs_q     <= hSyncIn;
      vs_q     <= vSyncIn;
      x_q      <= x_d;
      y_q      <= y_d;
      hper_q   <= hper_d;
      hwid_q   <= hwid_d;
      vlines_q <= vlines_d;
      vwid_q   <= vwid_d;
      hseen_q  <= hseen_d;
      vseen_q  <= vseen_d;
      meas_h_q <= meas_h_d;
      meas_v_q <= meas_v_d;
    end
  end

`ifdef ERROR_COUNT_EN
  logic [15:0] err_cnt_q;
  assign errCount = err_cnt_q;
`endif

  always_ff @(posedge pixelClk) begin
    if (rst) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
`ifdef ERROR_COUNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_q     <= CHECK;
            good_q      <= '0;
            frame_err_q <= 1'b0;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            frame_err_q <= 1'b0;
            if (!(frame_err_q | h_bad | wd_bad) && vlines_q == V_TOT && vwid_q == V_SLEN) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end else if (h_bad | wd_bad) begin
            frame_err_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (drop) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
`ifdef ERROR_COUNT_EN
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
`endif
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign lockedOut   = locked_q;
  assign xCor        = x_q;
  assign yCor        = y_q;
  assign hVis        = locked_q & (x_q < X_VIS);
  assign vVis        = locked_q & (y_q < Y_VIS);
  assign de          = hVis & vVis;
  assign measHPeriod = meas_h_q;
  assign measVLines  = meas_v_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - directed bench for vga_timing_rx on a reduced-size raster
module tb_vga_timing_rx;

  // Reduced raster keeps each frame short; relationships mirror 640x480.
  localparam int HV = 16, HSS = 20, HSL = 6, HT = 32;
  localparam int VV = 12, VSS = 14, VSL = 2, VT = 18, LF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hSyncIn, vSyncIn;
  logic        lockedOut, hVis, vVis, de;
  logic [9:0]  xCor, yCor, measVLines;
  logic [10:0] measHPeriod;
`ifdef ERROR_COUNT_EN
  logic [15:0] errCount;
`endif

  vga_timing_rx #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .pixelClk(clk), .rst(rst), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .lockedOut(lockedOut), .xCor(xCor), .yCor(yCor), .hVis(hVis), .vVis(vVis),
    .de(de), .measHPeriod(measHPeriod), .measVLines(measVLines)
`ifdef ERROR_COUNT_EN
    , .errCount(errCount)
`endif
  );

  int total = 0, bad = 0;
  int gx, gy, line_len, hs_len, sx, sy, hcnt, vfalls, nh;
  bit hold, hs_prev, vs_prev, hfell, hrose, vfell;
  logic lk_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    hSyncIn = hold ? 1'b1 : !(gx >= HSS && gx < HSS + hs_len);
    vSyncIn = !(gy >= VSS && gy < VSS + VSL);
  endtask

  // One clock: record what the DUT sampled at the posedge, then advance the
  // generator at the negedge. After return, sx/sy are the generator values the
  // DUT just sampled, so a tracking DUT shows xCor==sx, yCor==sy.
  task automatic step();
    lk_prev = lockedOut;
    @(posedge clk);
    hfell   = !rst && hs_prev && !hSyncIn;
    hrose   = !rst && !hs_prev && hSyncIn;
    vfell   = !rst && vs_prev && !vSyncIn;
    hs_prev = rst ? 1'b1 : hSyncIn;
    vs_prev = rst ? 1'b1 : vSyncIn;
    sx = gx;
    sy = gy;
    hcnt = hfell ? 1 : hcnt + 1;
    if (hfell) nh++;
    if (vfell) vfalls++;
    @(negedge clk);
    gx++;
    if (gx >= line_len) begin
      gx = 0;
      line_len = HT;
      hs_len = HSL;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
    drive();
  endtask

  task automatic goto(input int ty, input int tx);
    int n;
    n = 0;
    while (!(gx == tx && gy == ty) && n < 2 * HT * VT) begin
      step();
      n++;
    end
  endtask

  task automatic relock(input string tag);
    int vf, n;
    vf = 0;
    n = 0;
    while (lockedOut !== 1'b1 && n < 5 * HT * VT) begin
      step();
      if (vfell) vf++;
      n++;
    end
    check({tag, "_relocked"}, lockedOut, 1);
    check({tag, "_relock_vfalls"}, vf, 3);
  endtask

  initial begin
    int n, early, xe, ye, dee, le;
    rst = 1'b1; hold = 1'b0;
    gx = 0; gy = 0; line_len = HT; hs_len = HSL;
    hs_prev = 1'b1; vs_prev = 1'b1; hcnt = 0; nh = 0; vfalls = 0;
    drive();
    repeat (4) step();
    check("rst_locked", lockedOut, 0);
    check("rst_x", xCor, 0);
    check("rst_y", yCor, 0);
    check("rst_de", de, 0);
    check("rst_measH", measHPeriod, 0);
    check("rst_measV", measVLines, 0);

    // Initial lock, first measurements
    rst = 1'b0; nh = 0; vfalls = 0; early = 0; n = 0;
    while (vfalls < 3 && n < 5 * HT * VT) begin
      step();
      n++;
      if (hfell && nh == 1) check("measH_first_fall", measHPeriod, 0);
      if (hfell && nh == 2) check("measH_second_fall", measHPeriod, HT);
      if (vfell && vfalls == 1) check("measV_first_fall", measVLines, 0);
      if (vfell && vfalls == 2) check("measV_second_fall", measVLines, VT);
      if (vfalls < 3 && lockedOut === 1'b1) early = 1;
    end
    check("lock_not_early", early, 0);
    check("lock_after_3rd_vfall", lockedOut, 1);
    check("unlocked_cycle_before", lk_prev, 0);

    // Two frames of cycle-exact tracking
    xe = 0; ye = 0; dee = 0; le = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      if (xCor !== 10'(sx)) xe++;
      if (yCor !== 10'(sy)) ye++;
      if (de !== (sx < HV && sy < VV) || hVis !== (sx < HV) || vVis !== (sy < VV)) dee++;
      if (lockedOut !== 1'b1) le++;
    end
    check("track_x_errors", xe, 0);
    check("track_y_errors", ye, 0);
    check("track_vis_errors", dee, 0);
    check("track_lock_errors", le, 0);

    // One line stretched to HT+1 cycles
    goto(3, HSS + HSL + 1);
    line_len = HT + 1;
    hfell = 1'b0; n = 0;
    while (!hfell && n < 4 * HT) begin step(); n++; end
    check("stretch_locked_before", lk_prev, 1);
    check("stretch_drop", lockedOut, 0);
    check("stretch_measH", measHPeriod, HT + 1);
`ifdef ERROR_COUNT_EN
    check("stretch_errCount", errCount, 1);
`endif
    relock("stretch");

    // Short hsync pulse
    goto(3, 0);
    hs_len = HSL - 1;
    hrose = 1'b0; n = 0;
    while (!hrose && n < 4 * HT) begin step(); n++; end
    check("short_locked_before", lk_prev, 1);
    check("short_drop", lockedOut, 0);
    relock("short");

    // hsync held high: watchdog
    goto(1, 0);
    hold = 1'b1; n = 0;
    while (lockedOut === 1'b1 && n < 4 * HT) begin step(); n++; end
    check("wd_locked_before", lk_prev, 1);
    check("wd_drop", lockedOut, 0);
    check("wd_cycles_since_fall", hcnt, 2 * HT + 2);
    check("wd_x_runs", xCor, sx);
    repeat (2 * HT) step();
    check("wd_x_wraps", xCor, sx);
    hold = 1'b0;
    relock("wd");

    // Mid-frame reset pulse
    goto(5, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_locked", lockedOut, 0);
    check("midrst_x", xCor, 0);
    check("midrst_y", yCor, 0);
    check("midrst_de", de, 0);
    check("midrst_measH", measHPeriod, 0);
    check("midrst_measV", measVLines, 0);
    relock("midrst");
    step();
    check("midrst_track_x", xCor, sx);
    check("midrst_track_de", de, (sx < HV && sy < VV));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
